// File: rtl/noc_pkg.sv
// Shared definitions for the 3x3 NoC router: port codes, arbiter sizing and state encoding.
package noc_pkg;

  localparam int N_REQ   = 5;
  localparam int GRANT_W = 3;

  localparam logic [GRANT_W-1:0] PORT_N    = 3'd0;
  localparam logic [GRANT_W-1:0] PORT_E    = 3'd1;
  localparam logic [GRANT_W-1:0] PORT_S    = 3'd2;
  localparam logic [GRANT_W-1:0] PORT_W    = 3'd3;
  localparam logic [GRANT_W-1:0] PORT_PE   = 3'd4;
  localparam logic [GRANT_W-1:0] PORT_NONE = 3'd5;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Reduce a small sum (0..9) into the port range 0..4.
  function automatic logic [GRANT_W-1:0] wrap5(input logic [3:0] v);
    return (v >= 4'd5) ? 3'(v - 4'd5) : v[2:0];
  endfunction

endpackage

// File: rtl/rr_pick5.sv
// Combinational round-robin picker: first set request bit scanning prio, prio+1, ... modulo 5.
module rr_pick5
  import noc_pkg::*;
(
  input  logic [N_REQ-1:0]   req,
  input  logic [GRANT_W-1:0] prio,
  output logic [GRANT_W-1:0] win,
  output logic               any
);

  logic [GRANT_W-1:0] cand_idx [N_REQ];
  logic [N_REQ-1:0]   cand_hit;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
      assign cand_idx[gi] = wrap5({1'b0, prio} + 4'(gi));
      assign cand_hit[gi] = (cand_idx[gi] < PORT_NONE) && req[cand_idx[gi]];
    end
  endgenerate

  // Walk from the lowest-priority candidate upward so the nearest hit wins.
  always_comb begin
    win = PORT_NONE;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) win = cand_idx[k];
    end
  end

  assign any = |req;

endmodule

// File: rtl/output_port_arbiter.sv
// Per-output-port wormhole arbiter: round-robin grant held from head to tail, one ack per flit moved.
module output_port_arbiter
  import noc_pkg::*;
#(
  parameter int PKT_LEN_MAX = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   tail,
  input  logic               out_ready,
  output logic [GRANT_W-1:0] grant,
  output logic               enable,
  output logic [N_REQ-1:0]   ack,
  output logic               busy,
  output logic               pkt_err
);

  arb_state_e         state_q;
  logic [GRANT_W-1:0] grant_q;
  logic [GRANT_W-1:0] prio_q;
  logic [7:0]         flit_cnt_q;
  logic [7:0]         flit_cnt_d;
  logic               pkt_err_q;

  logic [N_REQ-1:0]   grant_oh;
  logic [GRANT_W-1:0] win;
  logic               any;
  logic               locked;
  logic               grant_legal;
  logic               tail_sel;
  logic               last_slot;
  logic               xfer;
  logic               release_now;

  rr_pick5 u_pick (
    .req  (req),
    .prio (prio_q),
    .win  (win),
    .any  (any)
  );

  // One-hot of the held grant; all-zero for NONE or an illegal code, which blocks any transfer.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_oh
      assign grant_oh[gi] = (grant_q == 3'(gi));
    end
  endgenerate

  assign locked      = (state_q == ARB_LOCKED);
  assign grant_legal = (grant_q < PORT_NONE);
  assign tail_sel    = |(tail & grant_oh);
  assign xfer        = locked & |(req & grant_oh) & out_ready;
  assign last_slot   = (flit_cnt_q == 8'(PKT_LEN_MAX - 1));
  assign release_now = xfer & (tail_sel | last_slot);
  assign flit_cnt_d  = (flit_cnt_q == 8'hFF) ? flit_cnt_q : flit_cnt_q + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      grant_q    <= PORT_NONE;
      prio_q     <= PORT_N;
      flit_cnt_q <= '0;
      pkt_err_q  <= 1'b0;
    end else begin
      pkt_err_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (any) begin
            grant_q    <= win;
            state_q    <= ARB_LOCKED;
            flit_cnt_q <= '0;
          end else begin
            grant_q <= PORT_NONE;
          end
        end
        ARB_LOCKED: begin
          if (!grant_legal) begin
            state_q <= ARB_IDLE;
            grant_q <= PORT_NONE;
          end else if (xfer) begin
            flit_cnt_q <= flit_cnt_d;
            if (release_now) begin
              state_q   <= ARB_IDLE;
              grant_q   <= PORT_NONE;
              prio_q    <= wrap5({1'b0, grant_q} + 4'd1);
              pkt_err_q <= ~tail_sel;
            end
          end
        end
        default: begin
          state_q <= ARB_IDLE;
          grant_q <= PORT_NONE;
        end
      endcase
    end
  end

  assign grant   = grant_q;
  assign enable  = xfer;
  assign ack     = xfer ? grant_oh : '0;
  assign busy    = locked;
  assign pkt_err = pkt_err_q;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed bench for output_port_arbiter: per-cycle expected outputs queued at drive time, checked mid-cycle.
module tb_output_port_arbiter;

  logic       clk;
  logic       rst;
  logic [4:0] req;
  logic [4:0] tail;
  logic       out_ready;
  logic [2:0] grant;
  logic       enable;
  logic [4:0] ack;
  logic       busy;
  logic       pkt_err;

  typedef struct packed {
    logic [2:0] g;
    logic       en;
    logic [4:0] a;
    logic       b;
    logic       e;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   n_step = 0;

  output_port_arbiter #(.PKT_LEN_MAX(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .tail      (tail),
    .out_ready (out_ready),
    .grant     (grant),
    .enable    (enable),
    .ack       (ack),
    .busy      (busy),
    .pkt_err   (pkt_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s step%0d: observed %0h expected %0h", tag, n_step, obs, exp);
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL scoreboard step%0d: observed empty queue expected an entry", n_step);
      return;
    end
    e = exp_q.pop_front();
    chk("grant",   8'(grant),   8'(e.g));
    chk("enable",  8'(enable),  8'(e.en));
    chk("ack",     8'(ack),     8'(e.a));
    chk("busy",    8'(busy),    8'(e.b));
    chk("pkt_err", 8'(pkt_err), 8'(e.e));
    $display("step %0d req=%b tail=%b rdy=%0d rst=%0d -> grant=%0d en=%0d ack=%b busy=%0d err=%0d",
             n_step, req, tail, out_ready, rst, grant, enable, ack, busy, pkt_err);
    n_step++;
  endtask

  // Drive one cycle of inputs and the outputs expected in that same cycle.
  task automatic step(input logic [4:0] r, input logic [4:0] t, input logic rdy,
                      input logic [2:0] g, input logic en, input logic [4:0] a,
                      input logic b, input logic e);
    req       = r;
    tail      = t;
    out_ready = rdy;
    exp_q.push_back('{g: g, en: en, a: a, b: b, e: e});
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    #1;
  endtask

  // Assert reset away from the clock edge; outputs must clear without waiting for an edge.
  task automatic do_reset();
    rst = 1'b1;
    exp_q.push_back('{g: 3'd5, en: 1'b0, a: 5'b0, b: 1'b0, e: 1'b0});
    #1;
    check_outputs();
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    tail = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Single-flit packet from S, then show prio moved to 3.
    step(5'b00100, 5'b00100, 1'b1, 3'd5, 1'b0, 5'b00000, 1'b0, 1'b0);
    step(5'b00100, 5'b00100, 1'b1, 3'd2, 1'b1, 5'b00100, 1'b1, 1'b0);
    step(5'b00000, 5'b00000, 1'b1, 3'd5, 1'b0, 5'b00000, 1'b0, 1'b0);
    step(5'b01011, 5'b01011, 1'b1, 3'd5, 1'b0, 5'b00000, 1'b0, 1'b0);
    step(5'b01011, 5'b01011, 1'b1, 3'd3, 1'b1, 5'b01000, 1'b1, 1'b0);
    step(5'b00000, 5'b00000, 1'b1, 3'd5, 1'b0, 5'b00000, 1'b0, 1'b0);

    // Round-robin over all five requesters from prio 0.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      logic [2:0] p;
      p = 3'(k % 5);
      step(5'b11111, 5'b11111, 1'b1, 3'd5, 1'b0, 5'b00000, 1'b0, 1'b0);
      step(5'b11111, 5'b11111, 1'b1, p, 1'b1, 5'(5'b00001 << p), 1'b1, 1'b0);
    end
    step(5'b00000, 5'b00000, 1'b1, 3'd5, 1'b0, 5'b00000, 1'b0, 1'b0);

    // Wormhole lock on E (prio=1), two stall cycles mid-packet, then PE wins from prio 2.
    step(5'b10011, 5'b00000, 1'b1, 3'd5, 1'b0, 5'b00000, 1'b0, 1'b0);
    step(5'b10011, 5'b00000, 1'b1, 3'd1, 1'b1, 5'b00010, 1'b1, 1'b0);
    step(5'b10011, 5'b00000, 1'b1, 3'd1, 1'b1, 5'b00010, 1'b1, 1'b0);
    step(5'b10011, 5'b00000, 1'b0, 3'd1, 1'b0, 5'b00000, 1'b1, 1'b0);
    step(5'b10011, 5'b00000, 1'b0, 3'd1, 1'b0, 5'b00000, 1'b1, 1'b0);
    step(5'b10011, 5'b00000, 1'b1, 3'd1, 1'b1, 5'b00010, 1'b1, 1'b0);
    step(5'b10011, 5'b00010, 1'b1, 3'd1, 1'b1, 5'b00010, 1'b1, 1'b0);
    step(5'b10011, 5'b00000, 1'b1, 3'd5, 1'b0, 5'b00000, 1'b0, 1'b0);
    step(5'b10011, 5'b10000, 1'b1, 3'd4, 1'b1, 5'b10000, 1'b1, 1'b0);
    step(5'b00000, 5'b00000, 1'b1, 3'd5, 1'b0, 5'b00000, 1'b0, 1'b0);

    // Bubble on W: req[3] drops for three cycles while N requests and is ignored.
    step(5'b01000, 5'b00000, 1'b1, 3'd5, 1'b0, 5'b00000, 1'b0, 1'b0);
    step(5'b01000, 5'b00000, 1'b1, 3'd3, 1'b1, 5'b01000, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(5'b00001, 5'b00000, 1'b1, 3'd3, 1'b0, 5'b00000, 1'b1, 1'b0);
    end
    step(5'b01000, 5'b01000, 1'b1, 3'd3, 1'b1, 5'b01000, 1'b1, 1'b0);
    step(5'b00000, 5'b00000, 1'b1, 3'd5, 1'b0, 5'b00000, 1'b0, 1'b0);

    // Missing tail from PE (prio=4): forced release after 16 flits, prio wraps to 0.
    step(5'b10000, 5'b00000, 1'b1, 3'd5, 1'b0, 5'b00000, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      step(5'b10000, 5'b00000, 1'b1, 3'd4, 1'b1, 5'b10000, 1'b1, 1'b0);
    end
    step(5'b11111, 5'b11111, 1'b1, 3'd5, 1'b0, 5'b00000, 1'b0, 1'b1);
    step(5'b11111, 5'b11111, 1'b1, 3'd0, 1'b1, 5'b00001, 1'b1, 1'b0);
    step(5'b00000, 5'b00000, 1'b1, 3'd5, 1'b0, 5'b00000, 1'b0, 1'b0);

    // Reset in the middle of an S packet (prio=1), then prio must be back at 0.
    step(5'b00100, 5'b00000, 1'b1, 3'd5, 1'b0, 5'b00000, 1'b0, 1'b0);
    step(5'b00100, 5'b00000, 1'b1, 3'd2, 1'b1, 5'b00100, 1'b1, 1'b0);
    do_reset();
    step(5'b11111, 5'b11111, 1'b1, 3'd5, 1'b0, 5'b00000, 1'b0, 1'b0);
    step(5'b11111, 5'b11111, 1'b1, 3'd0, 1'b1, 5'b00001, 1'b1, 1'b0);
    step(5'b00000, 5'b00000, 1'b1, 3'd5, 1'b0, 5'b00000, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
